des_input_collector: RTL and testbench
======================================

# des_input_collector

Front-panel input stage for the DES text encryptor; it is the input counterpart to the LCD prompt driver. It debounces the entry pushbutton and captures four 16-bit switch words for the 64-bit key, then four for the 64-bit plaintext, always MSB word first. It then waits for a final confirm press and hands both operands to the DES core with a one-cycle start pulse. Its `step` output tells the LCD driver which prompt to show.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable samples needed before a button level is accepted (10 ms at 50 MHz). Minimum value is 1.
- `CNT_W`, default 20: debounce counter width. It must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `btn`  in  1  raw pushbutton, active-low (pressed = 0), asynchronous to `clk`.
- `sw`  in  16  data switches, sampled on an accepted press.
- `des_done`  in  1  completion strobe from the DES core.
- `step`  out  4  current entry step (encoding below).
- `key`  out  64  assembled key.
- `text`  out  64  assembled plaintext.
- `last_word`  out  16  most recently captured switch word, for LCD echo.
- `des_start`  out  1  one-cycle start strobe to the DES core.
- `busy`  out  1  high in the ENCR step only.

## Operation

Button path:
- Two-flop synchronizer: `s1` then `s2`, both reset to 1.
- Debounce register `stable` resets to 1; counter `cnt` resets to 0.
- Each edge where `s2` ≠ `stable`:
  - if `cnt` = DEBOUNCE_CYCLES−1: `stable` ← `s2` and `cnt` ← 0;
  - otherwise `cnt` increments.
- Each edge where `s2` = `stable`: `cnt` ← 0. A glitch shorter than DEBOUNCE_CYCLES samples therefore produces nothing.
- `press` is a registered pulse, set at the edge where `stable` goes from 1 to 0, and high for exactly one cycle. Releases generate no event.

State machine (`step` encoding):
- IDLE = 0
- KEY0–KEY3 = 1–4
- VAL0–VAL3 = 5–8
- ARMED = 9
- ENCR = 10
- DONE = 11

Transitions:
- IDLE, on `press`: go to KEY0. Nothing is captured (this press dismisses the welcome screen).
- KEYi, on `press`: `key[63−16i : 48−16i]` ← `sw` and `last_word` ← `sw`; advance. KEY3 advances to VAL0.
- VALi, on `press`: `text[63−16i : 48−16i]` ← `sw` and `last_word` ← `sw`; advance. VAL3 advances to ARMED.
- ARMED, on `press`: go to ENCR; `des_start` ← 1 for exactly that one cycle.
- ENCR: `busy` = 1; `press` is ignored; `des_done` moves to DONE.
- DONE: terminal. `press` and `des_done` are ignored; only `rst` leaves it.
- `des_done` outside ENCR is ignored.
- Unused `step` codes (12–15) return to IDLE on the next edge and drive no capture.

Data rules:
- `key`, `text` and `last_word` hold their values until overwritten or reset; there is no clear on IDLE.
- `sw` is the value present at the edge that consumes `press`.

## Timing

- Reset values: `step`=0, `key`=0, `text`=0, `last_word`=0, `des_start`=0, `busy`=0. Internal: `s1`=`s2`=`stable`=1, `cnt`=0, `press`=0.
- Reset asserted mid-operation, including mid-debounce or in ENCR, returns to all reset values immediately; no `des_start` is emitted.
- Latency:
  - `btn` first sampled low at edge E: `s2` is low after E+1; `press` is high after edge E+1+DEBOUNCE_CYCLES.
  - The FSM consumes `press` at edge E+2+DEBOUNCE_CYCLES; `step`, captured data and `des_start` update on that same edge.
- `busy` is combinational from state: high exactly while `step`=10.
- Simultaneous events:
  - `press` and `des_done` in the same ENCR cycle: go to DONE; the press is discarded.
  - `press` arriving in the same cycle as reset deassertion is not possible, because `press` is 0 out of reset.
- Back-to-back presses require a release of at least DEBOUNCE_CYCLES samples between them.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

1. **Full entry.**
   - Stimulus: one IDLE press, then key words 0x1334, 0x5779, 0x9BBC, 0xDFF1 and text words 0x0123, 0x4567, 0x89AB, 0xCDEF, then a confirm press.
   - Required: `key`=0x133457799BBCDFF1 and `text`=0x0123456789ABCDEF. `step` walks 0→11 (after `des_done`). `des_start` is high for exactly 1 cycle. `last_word`=0xCDEF.
2. **Debounce latency.**
   - Stimulus: `btn` low, first sampled at edge E, and held.
   - Required: `press` high only after edge E+5. `step` changes 0→1 at edge E+6.
3. **Glitch rejection.**
   - Stimulus: `btn` low for 3 samples, then high; repeat 10 times.
   - Required: `step` stays 0 and `press` is never asserted.
4. **ENCR masking.**
   - Stimulus: a press during ENCR; then `des_done` and a press in the same cycle.
   - Required: `step` stays 10 after the first press. It moves to 11 on the simultaneous event. `des_start` pulses only once in total.
5. **Reset mid-entry.**
   - Stimulus: assert `rst` while in VAL1 with `key` loaded.
   - Required: all outputs return to 0 asynchronously. A subsequent sequence restarts from IDLE.
6. **Stray done and release.**
   - Stimulus: `des_done` pulses in IDLE and in KEY2; hold `btn` pressed for 100 cycles, then release.
   - Required: no state change from either `des_done`. Exactly one step advance for the long press, and none on release.

Source files
------------

// File: rtl/des_input_collector.sv
// des_input_collector: debounces the entry button, collects 4 key words and 4 text
// words (MSB word first), then issues a one-cycle start to the DES core on confirm.
`default_nettype none

module des_input_collector #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    input  logic [15:0] sw,
    input  logic        des_done,
    output logic [3:0]  step,
    output logic [63:0] key,
    output logic [63:0] text,
    output logic [15:0] last_word,
    output logic        des_start,
    output logic        busy
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_KEY0  = 4'd1;
    localparam logic [3:0] S_KEY1  = 4'd2;
    localparam logic [3:0] S_KEY2  = 4'd3;
    localparam logic [3:0] S_KEY3  = 4'd4;
    localparam logic [3:0] S_VAL0  = 4'd5;
    localparam logic [3:0] S_VAL1  = 4'd6;
    localparam logic [3:0] S_VAL2  = 4'd7;
    localparam logic [3:0] S_VAL3  = 4'd8;
    localparam logic [3:0] S_ARMED = 4'd9;
    localparam logic [3:0] S_ENCR  = 4'd10;
    localparam logic [3:0] S_DONE  = 4'd11;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic             press;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       state;
    logic [3:0][15:0] key_w;
    logic [3:0][15:0] text_w;
    logic [1:0]       w_pos;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            press <= 1'b0;
            if (s2 != stable) begin
                if (cnt == CNT_MAX) begin
                    stable <= s2;
                    cnt    <= '0;
                    // Only the 1->0 acceptance (a press) produces an event.
                    press  <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Word slot within the current group; states 1..4 and 5..8 share low bits,
    // and slot 0 lands in the most significant word.
    assign w_pos = 2'd3 - (state[1:0] - 2'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            key_w     <= '0;
            text_w    <= '0;
            last_word <= '0;
            des_start <= 1'b0;
        end else begin
            des_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (press) state <= S_KEY0;
                end
                S_KEY0, S_KEY1, S_KEY2, S_KEY3: begin
                    if (press) begin
                        key_w[w_pos] <= sw;
                        last_word    <= sw;
                        state        <= state + 4'd1;
                    end
                end
                S_VAL0, S_VAL1, S_VAL2, S_VAL3: begin
                    if (press) begin
                        text_w[w_pos] <= sw;
                        last_word     <= sw;
                        state         <= state + 4'd1;
                    end
                end
                S_ARMED: begin
                    if (press) begin
                        state     <= S_ENCR;
                        des_start <= 1'b1;
                    end
                end
                S_ENCR: begin
                    if (des_done) state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign step = state;
    assign key  = key_w;
    assign text = text_w;
    assign busy = (state == S_ENCR);

endmodule

`default_nettype wire

// File: tb/tb_des_input_collector.sv
// Bench for des_input_collector: directed entry table, corner sequences, and a
// randomized run compared against a run-length/step-count reference model.
`default_nettype none

module tb_des_input_collector;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn = 1'b1;
    logic [15:0] sw  = '0;
    logic        des_done = 1'b0;
    logic [3:0]  step;
    logic [63:0] key;
    logic [63:0] text;
    logic [15:0] last_word;
    logic        des_start;
    logic        busy;

    des_input_collector #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .btn(btn), .sw(sw), .des_done(des_done),
        .step(step), .key(key), .text(text), .last_word(last_word),
        .des_start(des_start), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int starts = 0;
    int presses = 0;

    always @(negedge clk) begin
        if (des_start) starts++;
        if (dut.press) presses++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ncyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; btn = 1'b1; des_done = 1'b0;
        ncyc(2);
        rst = 1'b1;
        ncyc(1);
    endtask

    task automatic press_btn(input logic [15:0] w);
        sw  = w;
        btn = 1'b0;
        ncyc(DC + 4);
        btn = 1'b1;
        ncyc(DC + 4);
    endtask

    // ---------------- reference model ----------------
    int          mstep;
    logic [63:0] mkey, mtext;
    logic [15:0] mlast;
    logic        mstart;
    int          cyc;
    int          q[$];
    logic        acc, rl;
    int          rlen;

    task automatic model_reset();
        mstep = 0; mkey = '0; mtext = '0; mlast = '0; mstart = 1'b0;
        cyc = 0; q.delete(); acc = 1'b1; rl = 1'b1; rlen = DC;
    endtask

    // A low run of DC raw samples after an accepted high level is a press,
    // consumed by the FSM three edges after the DC-th sample.
    task automatic model_edge(input logic b, input logic [15:0] s, input logic d);
        logic pr;
        pr = 1'b0;
        cyc++;
        if (q.size() > 0 && q[0] == cyc) begin
            pr = 1'b1;
            void'(q.pop_front());
        end
        if (b == rl) rlen++;
        else begin rl = b; rlen = 1; end
        if (rl != acc && rlen == DC) begin
            acc = rl;
            if (!acc) q.push_back(cyc + 3);
        end
        mstart = 1'b0;
        if (mstep == 10) begin
            if (d) mstep = 11;
        end else if (mstep != 11 && pr) begin
            if (mstep >= 1 && mstep <= 4) begin
                mkey[63 - 16*(mstep-1) -: 16] = s; mlast = s;
            end else if (mstep >= 5 && mstep <= 8) begin
                mtext[63 - 16*(mstep-5) -: 16] = s; mlast = s;
            end
            if (mstep == 9) mstart = 1'b1;
            mstep++;
        end
    endtask

    typedef struct {
        logic [15:0] w;
        logic [3:0]  st;
        logic [15:0] lw;
        logic        bz;
    } vec_t;

    vec_t tab[10];
    int   snap;
    int   runleft;

    initial begin
        tab[0] = '{16'hFFFF, 4'd1,  16'h0000, 1'b0};
        tab[1] = '{16'h1334, 4'd2,  16'h1334, 1'b0};
        tab[2] = '{16'h5779, 4'd3,  16'h5779, 1'b0};
        tab[3] = '{16'h9BBC, 4'd4,  16'h9BBC, 1'b0};
        tab[4] = '{16'hDFF1, 4'd5,  16'hDFF1, 1'b0};
        tab[5] = '{16'h0123, 4'd6,  16'h0123, 1'b0};
        tab[6] = '{16'h4567, 4'd7,  16'h4567, 1'b0};
        tab[7] = '{16'h89AB, 4'd8,  16'h89AB, 1'b0};
        tab[8] = '{16'hCDEF, 4'd9,  16'hCDEF, 1'b0};
        tab[9] = '{16'hAAAA, 4'd10, 16'hCDEF, 1'b1};

        do_reset();
        check("rst_step", 64'(step), 64'd0);
        check("rst_key", key, 64'd0);
        check("rst_text", text, 64'd0);
        check("rst_last", 64'(last_word), 64'd0);
        check("rst_start_busy", 64'({des_start, busy}), 64'd0);

        // Full entry walk
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            press_btn(tab[i].w);
            check($sformatf("entry_step[%0d]", i), 64'(step), 64'(tab[i].st));
            check($sformatf("entry_last[%0d]", i), 64'(last_word), 64'(tab[i].lw));
            check($sformatf("entry_busy[%0d]", i), 64'(busy), 64'(tab[i].bz));
        end
        check("entry_key", key, 64'h133457799BBCDFF1);
        check("entry_text", text, 64'h0123456789ABCDEF);
        check("entry_starts", 64'(starts), 64'd1);

        // ENCR masking: plain press ignored, then press + done together
        press_btn(16'h5555);
        check("encr_press_ignored", 64'(step), 64'd10);
        btn = 1'b0;
        ncyc(DC + 2);
        des_done = 1'b1;
        ncyc(1);
        des_done = 1'b0;
        check("encr_done_simul", 64'(step), 64'd11);
        btn = 1'b1;
        ncyc(DC + 4);
        press_btn(16'h7777);
        des_done = 1'b1; ncyc(1); des_done = 1'b0;
        check("done_terminal", 64'(step), 64'd11);
        check("done_busy", 64'(busy), 64'd0);
        check("encr_starts", 64'(starts), 64'd1);
        check("done_last_hold", 64'(last_word), 64'hCDEF);

        // Debounce latency
        do_reset();
        btn = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) begin
                check("lat_press_E4", 64'(dut.press), 64'd0);
                check("lat_step_E4", 64'(step), 64'd0);
            end
            if (k == 5) begin
                check("lat_press_E5", 64'(dut.press), 64'd1);
                check("lat_step_E5", 64'(step), 64'd0);
            end
            if (k == 6) begin
                check("lat_press_E6", 64'(dut.press), 64'd0);
                check("lat_step_E6", 64'(step), 64'd1);
            end
        end
        @(negedge clk);
        btn = 1'b1;
        ncyc(DC + 4);

        // Glitch rejection
        do_reset();
        snap = presses;
        for (int g = 0; g < 10; g++) begin
            btn = 1'b0; ncyc(DC - 1);
            btn = 1'b1; ncyc(DC - 1);
        end
        ncyc(DC + 2);
        check("glitch_step", 64'(step), 64'd0);
        check("glitch_press", 64'(presses - snap), 64'd0);

        // Reset mid-entry (in VAL1)
        do_reset();
        press_btn(16'h0000);
        press_btn(16'hA1A1); press_btn(16'hB2B2); press_btn(16'hC3C3); press_btn(16'hD4D4);
        press_btn(16'hE5E5);
        check("mid_step", 64'(step), 64'd6);
        check("mid_key", key, 64'hA1A1B2B2C3C3D4D4);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_step", 64'(step), 64'd0);
        check("async_key", key, 64'd0);
        check("async_text_last", {text[47:0], last_word}, 64'd0);
        check("async_start_busy", 64'({des_start, busy}), 64'd0);
        ncyc(2);
        rst = 1'b1;
        ncyc(1);
        press_btn(16'h1111);
        check("restart_step", 64'(step), 64'd1);
        check("restart_key_clear", key, 64'd0);

        // Stray done and long press
        do_reset();
        des_done = 1'b1; ncyc(1); des_done = 1'b0; ncyc(2);
        check("stray_idle", 64'(step), 64'd0);
        press_btn(16'h0001); press_btn(16'h0002); press_btn(16'h0003);
        check("at_key2", 64'(step), 64'd3);
        des_done = 1'b1; ncyc(1); des_done = 1'b0; ncyc(2);
        check("stray_key2", 64'(step), 64'd3);
        sw = 16'h0BAD;
        btn = 1'b0; ncyc(100);
        check("long_press", 64'(step), 64'd4);
        btn = 1'b1; ncyc(20);
        check("release_none", 64'(step), 64'd4);
        check("long_last", 64'(last_word), 64'h0BAD);

        // Randomized run against the reference model
        for (int ep = 0; ep < 3; ep++) begin
            do_reset();
            model_reset();
            runleft = 0;
            @(negedge clk);
            repeat (1200) begin
                if (runleft == 0) begin
                    btn = ~btn;
                    runleft = $urandom_range(1, 8);
                end
                runleft--;
                sw = 16'($urandom);
                des_done = ($urandom % 16) == 0;
                @(posedge clk);
                model_edge(btn, sw, des_done);
                @(negedge clk);
                check("rnd_step", 64'(step), 64'(mstep));
                check("rnd_key", key, mkey);
                check("rnd_text", text, mtext);
                check("rnd_last", 64'(last_word), 64'(mlast));
                check("rnd_start_busy", 64'({des_start, busy}), 64'({mstart, mstep == 10}));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
